// File: rtl/sram_client_arbiter_pkg.sv
// Shared types and width helpers for the SRAM client arbiter.
package sram_arb_pkg;

    typedef enum logic {
        S_ARB_IDLE  = 1'b0,
        S_ARB_OWNED = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Client index width; a single client pair still needs one bit.
    function automatic int CLIENT_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_client_arbiter_rr_picker.sv
// Combinational winner selection: lowest index (fixed) or first requester
// at or after the start pointer, wrapping at N_CLIENTS (round-robin).
module arb_rr_picker
    import sram_arb_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int IDX_W     = CLIENT_IDX_W(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]     start,
    input  arb_mode_t            mode,
    output logic [N_CLIENTS-1:0] winner,
    output logic [IDX_W-1:0]     winner_idx
);

    always_comb begin
        int   cand;
        logic found;
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        for (int off = 0; off < N_CLIENTS; off++) begin
            cand = (mode == ARB_RR) ? (int'(start) + off) % N_CLIENTS : off;
            if (!found && req[cand]) begin
                found       = 1'b1;
                winner[cand] = 1'b1;
                winner_idx  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_client_arbiter.sv
// Registered request/grant arbiter sharing one SRAM port among N clients,
// with burst lock and a read-latency tag pipeline routing data back.
module sram_client_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                N_CLIENTS = 4,
    parameter int                ADDR_W    = 18,
    parameter int                DATA_W    = 16,
    parameter int                RD_LAT    = 2,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
    input  logic                          CLOCK_50_I,
    input  logic                          Reset,
    input  logic                          mode,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          lock,
    input  logic [N_CLIENTS-1:0]          cl_we_n,
    input  logic [N_CLIENTS*ADDR_W-1:0]   cl_address,
    input  logic [N_CLIENTS*DATA_W-1:0]   cl_write_data,
    output logic [N_CLIENTS-1:0]          grant,
    output logic [N_CLIENTS-1:0]          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic [ADDR_W-1:0]             SRAM_address,
    output logic [DATA_W-1:0]             SRAM_write_data,
    output logic                          SRAM_we_n,
    input  logic [DATA_W-1:0]             SRAM_read_data
);

    localparam int IDX_W = CLIENT_IDX_W(N_CLIENTS);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] id;
    } tag_t;

    arb_state_t           state, next_state;
    logic [N_CLIENTS-1:0] next_grant, win_onehot;
    logic [IDX_W-1:0]     owner, next_owner, rr_ptr, next_rr, win_idx;
    logic                 rearb, access;
    tag_t                 tag_pipe [RD_LAT];
    tag_t                 tag_in, tag_tail;
    logic [DATA_W-1:0]    rd_data_q;

    arb_rr_picker #(.N_CLIENTS(N_CLIENTS), .IDX_W(IDX_W)) u_picker (
        .req        (req),
        .start      (rr_ptr),
        .mode       (arb_mode_t'(mode)),
        .winner     (win_onehot),
        .winner_idx (win_idx)
    );

    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            state  <= S_ARB_IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state  <= next_state;
            grant  <= next_grant;
            owner  <= next_owner;
            rr_ptr <= next_rr;
        end
    end

    always_comb begin
        next_state = state;
        next_grant = grant;
        next_owner = owner;
        next_rr    = rr_ptr;
        case (state)
            S_ARB_IDLE:  rearb = 1'b1;
            S_ARB_OWNED: rearb = !(req[owner] && lock[owner]);
            default:     rearb = 1'b1;
        endcase
        if (rearb) begin
            if (|req) begin
                next_state = S_ARB_OWNED;
                next_grant = win_onehot;
                next_owner = win_idx;
                // Pointer follows the last winner and wraps at N_CLIENTS, not a power of two.
                next_rr    = (int'(win_idx) == N_CLIENTS - 1) ? '0 : win_idx + 1'b1;
            end else begin
                next_state = S_ARB_IDLE;
                next_grant = '0;
            end
        end
    end

    always_comb begin
        access          = grant[owner] && req[owner];
        SRAM_address    = IDLE_ADDR;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (access) begin
            SRAM_address    = cl_address[owner*ADDR_W +: ADDR_W];
            SRAM_write_data = cl_write_data[owner*DATA_W +: DATA_W];
            SRAM_we_n       = cl_we_n[owner];
        end
    end

    always_comb begin
        tag_in.valid = access && cl_we_n[owner];
        tag_in.id    = owner;
        tag_tail     = tag_pipe[RD_LAT-1];
        rd_valid     = '0;
        rd_data      = rd_data_q;
        if (tag_tail.valid) begin
            rd_valid[tag_tail.id] = 1'b1;
            rd_data               = SRAM_read_data;
        end
    end

    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            // NOTE: the tag pipeline is control state, so it is reset; clearing it drops reads in flight.
            tag_pipe  <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            rd_data_q <= rd_data;
        end
    end

endmodule

// File: tb/tb_sram_client_arbiter.sv
// Self-checking bench: directed grant table, hand-written read/write/reset
// sequences and random traffic against a transaction-level reference model.
module tb_sram_client_arbiter;

    localparam int                N         = 4;
    localparam int                ADDR_W    = 18;
    localparam int                DATA_W    = 16;
    localparam int                RD_LAT    = 2;
    localparam logic [ADDR_W-1:0] IDLE_ADDR = '0;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      mode;
    logic [N-1:0]              req, lock, cl_we_n;
    logic [N*ADDR_W-1:0]       cl_address;
    logic [N*DATA_W-1:0]       cl_write_data;
    logic [N-1:0]              grant, rd_valid;
    logic [DATA_W-1:0]         rd_data, SRAM_write_data, SRAM_read_data;
    logic [ADDR_W-1:0]         SRAM_address;
    logic                      SRAM_we_n;

    logic [ADDR_W-1:0]         c_addr [N];
    logic [DATA_W-1:0]         c_wd   [N];
    logic [ADDR_W-1:0]         hist   [RD_LAT];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } rd_rec_t;

    rd_rec_t           m_q[$];
    int                m_owner = -1;
    int                m_rr    = 0;
    logic [DATA_W-1:0] m_last  = '0;
    bit                m_last_known = 1'b0;

    logic [N-1:0]      obs_grant, obs_rd_valid;
    logic [DATA_W-1:0] obs_rd_data, obs_wdata;
    logic [ADDR_W-1:0] obs_addr;
    logic              obs_we_n;

    typedef struct {
        logic         md;
        logic [N-1:0] r;
        logic [N-1:0] lk;
        logic [N-1:0] exp_grant;
    } vec_t;

    vec_t vecs [28];

    always #5 clk = ~clk;

    sram_client_arbiter #(
        .N_CLIENTS (N),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .IDLE_ADDR (IDLE_ADDR)
    ) dut (
        .CLOCK_50_I      (clk),
        .Reset           (rst),
        .mode            (mode),
        .req             (req),
        .lock            (lock),
        .cl_we_n         (cl_we_n),
        .cl_address      (cl_address),
        .cl_write_data   (cl_write_data),
        .grant           (grant),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data)
    );

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign cl_address[i*ADDR_W +: ADDR_W]    = c_addr[i];
        assign cl_write_data[i*DATA_W +: DATA_W] = c_wd[i];
    end

    // SRAM stand-in: returns (address + 0x1000) RD_LAT cycles after the address is presented.
    always @(posedge clk) begin
        hist[0] <= SRAM_address;
        for (int i = 1; i < RD_LAT; i++) hist[i] <= hist[i-1];
    end
    assign SRAM_read_data = DATA_W'(hist[RD_LAT-1] + 18'h01000);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input logic md, input int start);
        int order [N];
        for (int k = 0; k < N; k++) order[k] = md ? (start + k) % N : k;
        foreach (order[k]) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    // One clock cycle: apply inputs, compare against the model mid-cycle, then advance the model.
    task automatic run(input logic md, input logic [N-1:0] r, input logic [N-1:0] lk, input logic [N-1:0] wn);
        logic [N-1:0]      eg, erv;
        logic [DATA_W-1:0] erd;
        logic              acc, keep, chk_data;
        mode = md; req = r; lock = lk; cl_we_n = wn;
        @(negedge clk);
        eg = '0; acc = 1'b0; keep = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            acc  = r[m_owner];
            keep = r[m_owner] && lk[m_owner];
        end
        check("grant", 32'(grant), 32'(eg));
        if (acc) begin
            check("sram_we_n", 32'(SRAM_we_n), 32'(wn[m_owner]));
            check("sram_addr", 32'(SRAM_address), 32'(c_addr[m_owner]));
            if (!wn[m_owner]) check("sram_wdata", 32'(SRAM_write_data), 32'(c_wd[m_owner]));
        end else begin
            check("idle_we_n", 32'(SRAM_we_n), 32'd1);
            check("idle_addr", 32'(SRAM_address), 32'(IDLE_ADDR));
        end
        erv = '0; erd = m_last; chk_data = m_last_known;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            erv[m_q[0].id] = 1'b1;
            erd = m_q[0].data;
            m_last = erd; m_last_known = 1'b1; chk_data = 1'b1;
            void'(m_q.pop_front());
        end
        check("rd_valid", 32'(rd_valid), 32'(erv));
        if (chk_data) check("rd_data", 32'(rd_data), 32'(erd));
        obs_grant = grant; obs_rd_valid = rd_valid; obs_rd_data = rd_data;
        obs_addr = SRAM_address; obs_wdata = SRAM_write_data; obs_we_n = SRAM_we_n;
        @(posedge clk); #1;
        if (acc && wn[m_owner])
            m_q.push_back('{due: cyc + RD_LAT, id: m_owner, data: DATA_W'(c_addr[m_owner] + 18'h01000)});
        if (!keep) begin
            if (r == '0) m_owner = -1;
            else begin
                m_owner = pick(r, md, m_rr);
                m_rr    = (m_owner + 1) % N;
            end
        end
        cyc++;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_we_n", 32'(SRAM_we_n), 32'd1);
            check("rst_addr", 32'(SRAM_address), 32'(IDLE_ADDR));
            check("rst_wdata", 32'(SRAM_write_data), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b0;
        m_q.delete(); m_owner = -1; m_rr = 0; m_last_known = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; req = '0; lock = '0; cl_we_n = '1;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = ADDR_W'(32'h40 * i + 5);
            c_wd[i]   = DATA_W'(32'h1111 * (i + 1));
        end

        vecs[0]  = '{1'b0, 4'b1010, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'b1010, 4'b0000, 4'b0010};
        vecs[2]  = '{1'b0, 4'b1000, 4'b0000, 4'b0010};
        vecs[3]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b1000};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000};
        vecs[7]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001};
        vecs[8]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010};
        vecs[9]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100};
        vecs[10] = '{1'b1, 4'b1111, 4'b0000, 4'b1000};
        vecs[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0001};
        vecs[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
        vecs[13] = '{1'b0, 4'b0100, 4'b0100, 4'b0000};
        for (int i = 14; i < 22; i++) vecs[i] = '{1'b0, 4'b0101, 4'b0100, 4'b0100};
        vecs[22] = '{1'b0, 4'b0101, 4'b0000, 4'b0100};
        vecs[23] = '{1'b0, 4'b0001, 4'b0000, 4'b0001};
        vecs[24] = '{1'b0, 4'b0000, 4'b0000, 4'b0001};
        vecs[25] = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
        vecs[26] = '{1'b0, 4'b0000, 4'b1111, 4'b0000};
        vecs[27] = '{1'b0, 4'b0000, 4'b1111, 4'b0000};

        reset_cycles(2);

        // Fixed priority, round-robin rotation, lock hold and lock-without-request.
        foreach (vecs[i]) begin
            run(vecs[i].md, vecs[i].r, vecs[i].lk, 4'b1111);
            check("table_grant", 32'(obs_grant), 32'(vecs[i].exp_grant));
        end

        // Back-to-back reads from clients 1 and 3 return to their issuers.
        c_addr[1] = 18'h00010; c_addr[3] = 18'h00020;
        run(1'b1, 4'b0010, 4'b0000, 4'b1111);
        run(1'b1, 4'b1010, 4'b0000, 4'b1111);
        check("rr_read1_addr", 32'(obs_addr), 32'h00010);
        run(1'b1, 4'b1000, 4'b0000, 4'b1111);
        check("rr_read3_addr", 32'(obs_addr), 32'h00020);
        run(1'b1, 4'b0000, 4'b0000, 4'b1111);
        check("route_valid_c1", 32'(obs_rd_valid), 32'b0010);
        check("route_data_c1", 32'(obs_rd_data), 32'h1010);
        run(1'b1, 4'b0000, 4'b0000, 4'b1111);
        check("route_valid_c3", 32'(obs_rd_valid), 32'b1000);
        check("route_data_c3", 32'(obs_rd_data), 32'h1020);

        // Write pass-through from client 0; writes never raise rd_valid.
        c_addr[0] = 18'h3A000; c_wd[0] = 16'hBEEF;
        run(1'b0, 4'b0001, 4'b0000, 4'b1110);
        check("wr_no_rd_valid", 32'(obs_rd_valid), 32'd0);
        run(1'b0, 4'b0001, 4'b0000, 4'b1110);
        check("wr_we_n", 32'(obs_we_n), 32'd0);
        check("wr_addr", 32'(obs_addr), 32'h3A000);
        check("wr_data", 32'(obs_wdata), 32'hBEEF);
        for (int k = 0; k < 4; k++) begin
            run(1'b0, 4'b0000, 4'b0000, 4'b1110);
            check("wr_no_rd_valid", 32'(obs_rd_valid), 32'd0);
        end

        // Reset one cycle after a read issue drops the read in flight.
        c_addr[2] = 18'h00155;
        run(1'b0, 4'b0100, 4'b0000, 4'b1111);
        run(1'b0, 4'b0100, 4'b0000, 4'b1111);
        check("pre_rst_grant", 32'(obs_grant), 32'b0100);
        reset_cycles(1);
        for (int k = 0; k < 3; k++) begin
            run(1'b0, 4'b0000, 4'b0000, 4'b1111);
            check("post_rst_no_rd", 32'(obs_rd_valid), 32'd0);
        end
        run(1'b0, 4'b0100, 4'b0000, 4'b1111);
        run(1'b0, 4'b0100, 4'b0000, 4'b1111);
        check("post_rst_grant", 32'(obs_grant), 32'b0100);

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                c_addr[i] = ADDR_W'($urandom);
                c_wd[i]   = DATA_W'($urandom);
            end
            run(1'($urandom), N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, N'($urandom));
        end
        for (int k = 0; k < RD_LAT + 2; k++) run(1'b0, '0, '0, '1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_client_arbiter.md
Name: sram_client_arbiter

Overview:
- Parametrised, registered arbiter that shares the single SRAM controller port among N_CLIENTS requesters (UART, decoder milestones, VGA, and future units).
- Generalises the fixed per-top-state SRAM mux into per-cycle request/grant arbitration.
- Selectable fixed-priority or round-robin mode, with a lock for burst ownership.
- Read-latency tag pipeline that routes each returned read word to the client that issued it.

Parameters:
- N_CLIENTS, 4, number of requesting clients (2..8).
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.
- RD_LAT, 2, cycles from address presented to SRAM_read_data valid (≥1).
- IDLE_ADDR, 18'd0, address driven when no client is granted.

Ports:
- CLOCK_50_I  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = fixed priority (client 0 highest), 1 = round-robin.
- req  in  N_CLIENTS  per-client access request.
- lock  in  N_CLIENTS  per-client hold-ownership request.
- cl_we_n  in  N_CLIENTS  per-client write enable, active-low.
- cl_address  in  N_CLIENTS*ADDR_W  packed client addresses; client i occupies bits [i*ADDR_W +: ADDR_W].
- cl_write_data  in  N_CLIENTS*DATA_W  packed client write data.
- grant  out  N_CLIENTS  one-hot registered grant.
- rd_valid  out  N_CLIENTS  one-hot; read data for client i is valid this cycle.
- rd_data  out  DATA_W  returned read word.
- SRAM_address  out  ADDR_W  to SRAM controller.
- SRAM_write_data  out  DATA_W  to SRAM controller.
- SRAM_we_n  out  1  to SRAM controller.
- SRAM_read_data  in  DATA_W  from SRAM controller.

Behaviour:
- Reset:
  - grant=0, rd_valid=0, tag pipeline cleared, rr pointer=0, state=S_ARB_IDLE.
  - SRAM_we_n=1, SRAM_address=IDLE_ADDR, SRAM_write_data=0.
  - Reset mid-operation discards in-flight reads; no rd_valid is produced for them.
- States:
  - S_ARB_IDLE: no owner. If req≠0, pick a winner and load grant, then go to S_ARB_OWNED; otherwise stay.
  - S_ARB_OWNED: owner k.
    - req[k] & lock[k]: keep k; other requests are ignored.
    - Otherwise: rearbitrate among the current req and go to S_ARB_OWNED with the new winner, or to S_ARB_IDLE with grant=0 if req=0.
    - A handover costs no bubble.
- Winner selection:
  - mode 0: lowest index with req set.
  - mode 1: first requester at or after rr_ptr (wrapping); rr_ptr ← winner+1 mod N_CLIENTS, updated only on a new grant, not while locked.
  - Changing mode takes effect at the next arbitration decision.
- SRAM drive (combinational from registered grant):
  - Granted client k with req[k]=1: SRAM_address=cl_address[k], SRAM_write_data=cl_write_data[k], SRAM_we_n=cl_we_n[k].
  - Granted client with req=0, or no grant: SRAM_we_n=1, SRAM_address=IDLE_ADDR.
  - A client issues one access per cycle in which grant[k] & req[k].
- Read return:
  - Each cycle with grant[k] & req[k] & cl_we_n[k] pushes {valid=1, id=k} into an RD_LAT-deep shift pipeline; other cycles push valid=0.
  - At the pipeline tail, rd_valid[id]=1 and rd_data=SRAM_read_data; otherwise rd_valid=0 and rd_data holds its last value.
  - Reads still in flight complete to their original client after a grant handover, including back-to-back reads from different clients.
- Writes generate no rd_valid.
- Simultaneous events:
  - Owner dropping req while another client raises req hands over in the same cycle.
  - lock without req grants nothing.
- Width rules:
  - Client index width is $clog2(N_CLIENTS), minimum 1.
  - rr_ptr wraps at N_CLIENTS, not at a power of two.

Decomposition:
- Package sram_arb_pkg holds: arb_state_t enum {S_ARB_IDLE, S_ARB_OWNED}, arb_mode_t enum {ARB_FIXED, ARB_RR}, and a CLIENT_IDX_W function.
- One sub-module, arb_rr_picker: combinational; inputs req vector, start pointer and mode; outputs one-hot winner and winner index.
- Tag pipeline and grant register stay in the top block.

Test Plan:
- Fixed priority: mode=0, req=4'b1010 held → grant=4'b0010 one cycle later; drop req[1] → grant=4'b1000 next cycle, with no idle cycle between.
- Round-robin fairness: mode=1, req=4'b1111 continuous with no lock → grant cycles 0001,0010,0100,1000,0001 on successive cycles.
- Lock: client 2 holds req+lock for 8 cycles while req[0]=1 → grant=0100 for all 8 cycles; clear lock[2] → grant=0001 the following cycle.
- Read routing: RD_LAT=2; client 1 reads addr 0x00010 at cycle t, client 3 reads 0x00020 at t+1; SRAM model returns addr+0x1000 → rd_valid=0010 with rd_data=0x1010 at t+2, rd_valid=1000 with 0x1020 at t+3.
- Write pass-through: granted client 0 with cl_we_n=0, addr 0x3A000, data 0xBEEF → SRAM_we_n=0 with matching address and data the same cycle; rd_valid stays 0 for all cycles.
- Reset mid-read: assert Reset one cycle after a read issue → grant=0, SRAM_we_n=1, and no rd_valid after Reset deasserts; a new request is granted normally afterwards.
